// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI transaction arbiter: FSM encodings, controller
// mode values and default sizing.
package spi_arb_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StGap   = 3'd4;

  localparam logic ModeSlave  = 1'b0;
  localparam logic ModeMaster = 1'b1;

  localparam int unsigned DefGapCycles = 4;
  localparam int unsigned DefTimeout   = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Returns a one-hot pick (all zero when nothing requests) and its index.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [IW:0] cand;
  logic        found;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
    if (found) pick[idx] = 1'b1;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI master datapath among NREQ requesters.
// Optional watchdog abort in RUN is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GAP_CYCLES = DefGapCycles,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  timeout_err,
  output logic [NREQ-1:0]       cs_n,
  output logic                  spi_en,
  output logic                  spi_mode,
  output logic                  spi_op_complete,
  input  logic                  spi_w_done,
  input  logic                  spi_ss_out
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [2:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic [NREQ-1:0]  arb_pick;
  logic [IW-1:0]    arb_idx;
  logic [CNT_W-1:0] sel_len;
  logic             active;
  logic             done_pulse;
  logic             timed_out;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req  (req),
    .ptr  (ptr_q),
    .pick (arb_pick),
    .idx  (arb_idx)
  );

  assign sel_len = req_len[arb_idx*CNT_W +: CNT_W];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    gap_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (|arb_pick) begin
          idx_d   = arb_idx;
          rem_d   = sel_len;
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          // Zero-length requests skip the controller entirely.
          state_d = (sel_len == '0) ? StGap : StStart;
        end
      end
      StStart: state_d = StRun;
      StRun: begin
        if (spi_w_done) begin
          if (rem_q == CNT_W'(1)) state_d = StDrain;
          else                    rem_d   = rem_q - 1'b1;
        end else if (timed_out) begin
          state_d = StDrain;
        end
      end
      StDrain: if (spi_ss_out) state_d = StGap;
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
    end
  end

  assign active     = state_q inside {StStart, StRun, StDrain};
  assign done_pulse = (state_q == StGap) && (gap_q == '0);

  always_comb begin
    gnt  = '0;
    done = '0;
    if (active)     gnt[idx_q]  = 1'b1;
    if (done_pulse) done[idx_q] = 1'b1;
  end

  assign cs_n            = ~gnt;
  assign spi_en          = (state_q == StStart);
  assign spi_op_complete = (state_q == StDrain);
  assign spi_mode        = ModeMaster;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] to_cnt_q;
  logic          aborted_q;

  assign timed_out = (state_q == StRun) && !spi_w_done && (to_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      to_cnt_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (state_q != StRun || spi_w_done) to_cnt_q <= '0;
      else                                to_cnt_q <= to_cnt_q + 1'b1;
      if (timed_out)              aborted_q <= 1'b1;
      else if (state_q == StIdle) aborted_q <= 1'b0;
    end
  end

  assign timeout_err = done_pulse & aborted_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign timed_out      = 1'b0;
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter: directed scenarios plus random traffic
// checked against a transaction-level round-robin model.
module tb_spi_txn_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TMO   = 16;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_len;
  logic [NREQ-1:0]       gnt, done, cs_n;
  logic                  timeout_err, spi_en, spi_mode, spi_op_complete;
  logic                  spi_w_done, spi_ss_out;

  int          checks = 0;
  int          errors = 0;
  int unsigned ptr_m  = 0;
  logic [NREQ-1:0] ones_v = '1;
  logic [NREQ-1:0] zero_v = '0;

  always #5 CLK = ~CLK;

  spi_txn_arbiter #(
    .NREQ       (NREQ),
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .req             (req),
    .req_len         (req_len),
    .gnt             (gnt),
    .done            (done),
    .timeout_err     (timeout_err),
    .cs_n            (cs_n),
    .spi_en          (spi_en),
    .spi_mode        (spi_mode),
    .spi_op_complete (spi_op_complete),
    .spi_w_done      (spi_w_done),
    .spi_ss_out      (spi_ss_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    chk("mode_master", spi_mode, 1);
    chk("gnt_onehot0", $onehot0(gnt), 1);
    chk("cs_at_most_one", ($countones(cs_n) >= NREQ - 1), 1);
`ifndef SPI_ARB_TIMEOUT_EN
    chk("timeout_err_tied", timeout_err, 0);
`endif
  endtask

  // Reference: first requester at or after the pointer, wrapping.
  function automatic int pick_m(input logic [NREQ-1:0] r, input int unsigned p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return int'((p + k) % NREQ);
    return -1;
  endfunction

  // Entered at an IDLE sample with req driven; leaves at the next IDLE sample.
  task automatic do_txn(input int w, input bit drop_req, input string tag);
    logic [NREQ-1:0] m, mn;
    int unsigned     len;
    m      = '0;
    m[w]   = 1'b1;
    mn     = ~m;
    len    = int'(req_len[w*CNT_W +: CNT_W]);
    ptr_m  = (w + 1) % NREQ;
    tick();
    if (len == 0) begin
      chk({tag, ":zl_en"}, spi_en, 0);
      chk({tag, ":zl_cs"}, cs_n, ones_v);
      chk({tag, ":zl_done"}, done, m);
    end else begin
      chk({tag, ":start_en"}, spi_en, 1);
      chk({tag, ":start_gnt"}, gnt, m);
      chk({tag, ":start_cs"}, cs_n, mn);
      spi_ss_out = 1'b0;
      tick();
      chk({tag, ":run_en"}, spi_en, 0);
      chk({tag, ":run_gnt"}, gnt, m);
      if (drop_req) req[w] = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk({tag, ":wait_op"}, spi_op_complete, 0);
          chk({tag, ":wait_cs"}, cs_n, mn);
        end
        spi_w_done = 1'b1;
        tick();
        spi_w_done = 1'b0;
        chk({tag, ":word_op"}, spi_op_complete, (i == int'(len) - 1) ? 1 : 0);
        chk({tag, ":word_gnt"}, gnt, m);
        chk({tag, ":word_done"}, done, zero_v);
      end
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk({tag, ":drain_op"}, spi_op_complete, 1);
        chk({tag, ":drain_cs"}, cs_n, mn);
      end
      spi_ss_out = 1'b1;
      tick();
      chk({tag, ":gap_done"}, done, m);
      chk({tag, ":gap_gnt"}, gnt, zero_v);
      chk({tag, ":gap_op"}, spi_op_complete, 0);
    end
    chk({tag, ":gap_cs"}, cs_n, ones_v);
    repeat (GAP - 1) begin
      tick();
      chk({tag, ":gap_done_low"}, done, zero_v);
      chk({tag, ":gap_cs_high"}, cs_n, ones_v);
      chk({tag, ":gap_en_low"}, spi_en, 0);
    end
    tick();
    chk({tag, ":idle_gnt"}, gnt, zero_v);
    chk({tag, ":idle_done"}, done, zero_v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST       = 1'b1;
    req        = '0;
    req_len    = '0;
    spi_w_done = 1'b0;
    spi_ss_out = 1'b1;
    #2 nRST = 1'b0;
    #10;
    chk("rst_gnt", gnt, zero_v);
    chk("rst_done", done, zero_v);
    chk("rst_cs", cs_n, ones_v);
    chk("rst_en", spi_en, 0);
    chk("rst_op", spi_op_complete, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_mode", spi_mode, 1);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Single request, three words.
    req = 2'b01;
    req_len[0 +: CNT_W] = 8'd3;
    do_txn(pick_m(req, ptr_m), 1'b0, "single");
    req = '0;

    // Fairness: both held, each one word.
    req = 2'b11;
    req_len = {8'd1, 8'd1};
    for (int t = 0; t < 6; t++) do_txn(pick_m(req, ptr_m), 1'b0, "fair");
    req = '0;

    // Zero length on requester 1.
    req = 2'b10;
    req_len = {8'd0, 8'd5};
    do_txn(pick_m(req, ptr_m), 1'b0, "zero_len");
    req = '0;

    // Withdraw after START; the transfer still completes.
    req = 2'b01;
    req_len = {8'd1, 8'd2};
    do_txn(pick_m(req, ptr_m), 1'b1, "withdraw");
    req = '0;

    // Reset in RUN after one of four words, while requester 0 holds the grant.
    req = 2'b11;
    req_len = {8'd1, 8'd4};
    if (pick_m(req, ptr_m) != 0) begin
      req = 2'b10;
      do_txn(pick_m(req, ptr_m), 1'b0, "pre_reset");
      req = 2'b11;
    end
    tick();
    chk("mrst_start_gnt", gnt, 2'b01);
    spi_ss_out = 1'b0;
    tick();
    spi_w_done = 1'b1;
    tick();
    spi_w_done = 1'b0;
    chk("mrst_run_gnt", gnt, 2'b01);
    #2 nRST = 1'b0;
    #1;
    chk("mrst_gnt", gnt, zero_v);
    chk("mrst_cs", cs_n, ones_v);
    chk("mrst_en", spi_en, 0);
    chk("mrst_op", spi_op_complete, 0);
    chk("mrst_done", done, zero_v);
    chk("mrst_mode", spi_mode, 1);
    ptr_m      = 0;
    spi_ss_out = 1'b1;
    @(negedge CLK);
    chk("mrst_done_held", done, zero_v);
    nRST = 1'b1;
    req_len = {8'd1, 8'd1};
    do_txn(pick_m(req, ptr_m), 1'b0, "post_reset");
    req = '0;

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int w;
      req = 2'b01;
      req_len = {8'd1, 8'd3};
      w = pick_m(req, ptr_m);
      ptr_m = (w + 1) % NREQ;
      tick();
      chk("tmo_start_en", spi_en, 1);
      spi_ss_out = 1'b0;
      req = '0;
      tick();
      chk("tmo_run_op", spi_op_complete, 0);
      repeat (TMO - 1) begin
        tick();
        chk("tmo_run_op", spi_op_complete, 0);
      end
      tick();
      chk("tmo_drain_op", spi_op_complete, 1);
      chk("tmo_drain_err", timeout_err, 0);
      spi_ss_out = 1'b1;
      tick();
      chk("tmo_done", done, 2'b01);
      chk("tmo_err", timeout_err, 1);
      tick();
      chk("tmo_err_pulse", timeout_err, 0);
      repeat (GAP - 1) tick();
      chk("tmo_idle_gnt", gnt, zero_v);
    end
`endif

    // Random traffic against the round-robin model.
    for (int r = 0; r < 30; r++) begin
      req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) req_len[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 3));
      if (req == '0) begin
        tick();
        chk("rand_idle_gnt", gnt, zero_v);
        chk("rand_idle_en", spi_en, 0);
        chk("rand_idle_done", done, zero_v);
      end else begin
        do_txn(pick_m(req, ptr_m), 1'($urandom_range(0, 1)), "rand");
      end
    end
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
